// File: rtl/st7735_cmd_ctrl_pkg.sv
// Shared definitions for the ST7735R command sequencer: opcodes, FSM encoding,
// MADCTL bit positions and the window-commit helper.
package st7735_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;

  localparam int MADCTL_MV = 5;
  localparam int MADCTL_MX = 6;
  localparam int MADCTL_MY = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_P,
    ST_RASET_P,
    ST_MADCTL_P,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_SKIP
  } state_e;

  // End is clamped to the last line, then raised to Start so the window is never inverted.
  function automatic logic [15:0] commit_end(input logic [15:0] s, input logic [15:0] e,
                                             input logic [15:0] last);
    logic [15:0] c;
    c = (e > last) ? last : e;
    return (s > c) ? s : c;
  endfunction

endpackage

// File: rtl/st7735_addr_map.sv
// Cursor + MADCTL to physical coordinates, in-range flag and linear address.
// Orientation bits only act when SPI2HDMI_MADCTL_EN is defined.
module st7735_addr_map
  import st7735_cmd_ctrl_pkg::*;
#(
  parameter int H_RES  = 160,
  parameter int V_RES  = 128,
  parameter int ADDR_W = 15
) (
  input  logic [15:0]       cur_x,
  input  logic [15:0]       cur_y,
  input  logic [7:0]        madctl,
  output logic [15:0]       phys_x,
  output logic [15:0]       phys_y,
  output logic              in_range,
  output logic [ADDR_W-1:0] addr
);
  localparam logic [15:0] X_LAST = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST = 16'(V_RES - 1);

`ifdef SPI2HDMI_MADCTL_EN
  logic [15:0] sw_x, sw_y;
  always_comb begin
    sw_x = madctl[MADCTL_MV] ? cur_y : cur_x;
    sw_y = madctl[MADCTL_MV] ? cur_x : cur_y;
    // Mirroring an out-of-range coordinate wraps to a value >= RES, so it stays out of range.
    phys_x = madctl[MADCTL_MX] ? X_LAST - sw_x : sw_x;
    phys_y = madctl[MADCTL_MY] ? Y_LAST - sw_y : sw_y;
  end
`else
  logic unused_madctl;
  assign unused_madctl = ^madctl;
  assign phys_x = cur_x;
  assign phys_y = cur_y;
`endif

  assign in_range = (phys_x <= X_LAST) && (phys_y <= Y_LAST);
  assign addr     = ADDR_W'(phys_y) * ADDR_W'(H_RES) + ADDR_W'(phys_x);

endmodule

// File: rtl/st7735_cmd_ctrl.sv
// ST7735R command-subset sequencer driving a frame-buffer write port, SPI clock domain.
// Build option: SPI2HDMI_MADCTL_EN makes MADCTL MV/MX/MY remap addresses.
module st7735_cmd_ctrl
  import st7735_cmd_ctrl_pkg::*;
#(
  parameter int H_RES  = 160,
  parameter int V_RES  = 128,
  parameter int ADDR_W = 15
) (
  input  logic              i_spi_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  input  logic              i_dc,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_disp_on,
  output logic [7:0]        o_madctl,
  output logic [2:0]        o_dbg_state
);
  // Handshake: i_byte/i_dc are consumed on every posedge where i_byte_valid is high;
  // there is no ready/backpressure, and the write port has no stall either.
  localparam logic [15:0] X_LAST = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST = 16'(V_RES - 1);

  state_e      state_q, state_d;
  logic [1:0]  pcnt_q, pcnt_d;
  logic [23:0] prm_q, prm_d;
  logic [15:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [7:0]  hi_q, hi_d, mad_q, mad_d;
  logic        disp_q, disp_d;
  logic        in_range, wr_hit;
  logic [15:0] unused_phys_x, unused_phys_y;

  st7735_addr_map #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_addr_map (
    .cur_x    (x_q),
    .cur_y    (y_q),
    .madctl   (mad_q),
    .phys_x   (unused_phys_x),
    .phys_y   (unused_phys_y),
    .in_range (in_range),
    .addr     (o_wr_addr)
  );

  always_ff @(posedge i_spi_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      prm_q   <= '0;
      xs_q    <= '0;
      xe_q    <= X_LAST;
      ys_q    <= '0;
      ye_q    <= Y_LAST;
      x_q     <= '0;
      y_q     <= '0;
      hi_q    <= '0;
      mad_q   <= '0;
      disp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      prm_q   <= prm_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ys_q    <= ys_d;
      ye_q    <= ye_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      mad_q   <= mad_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    prm_d   = prm_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ys_d    = ys_q;
    ye_d    = ye_q;
    x_d     = x_q;
    y_d     = y_q;
    hi_d    = hi_q;
    mad_d   = mad_q;
    disp_d  = disp_q;
    wr_hit  = 1'b0;
    if (i_byte_valid && !i_dc) begin
      case (i_byte)
        CMD_CASET:   begin state_d = ST_CASET_P; pcnt_d = '0; end
        CMD_RASET:   begin state_d = ST_RASET_P; pcnt_d = '0; end
        CMD_RAMWR:   begin state_d = ST_RAMWR_HI; x_d = xs_q; y_d = ys_q; end
        CMD_MADCTL:  state_d = ST_MADCTL_P;
        CMD_DISPON:  begin state_d = ST_IDLE; disp_d = 1'b1; end
        CMD_DISPOFF: begin state_d = ST_IDLE; disp_d = 1'b0; end
        CMD_SWRESET: begin
          state_d = ST_IDLE;
          pcnt_d  = '0;
          prm_d   = '0;
          xs_d    = '0;
          xe_d    = X_LAST;
          ys_d    = '0;
          ye_d    = Y_LAST;
          x_d     = '0;
          y_d     = '0;
          hi_d    = '0;
          mad_d   = '0;
          disp_d  = 1'b0;
        end
        default:     state_d = ST_SKIP;
      endcase
    end else if (i_byte_valid) begin
      case (state_q)
        ST_CASET_P, ST_RASET_P: begin
          // prm_q collects {start_hi, start_lo, end_hi}; the 4th byte commits directly.
          prm_d  = {prm_q[15:0], i_byte};
          pcnt_d = pcnt_q + 2'd1;
          if (pcnt_q == 2'd3) begin
            state_d = ST_IDLE;
            if (state_q == ST_CASET_P) begin
              xs_d = prm_q[23:8];
              xe_d = commit_end(prm_q[23:8], {prm_q[7:0], i_byte}, X_LAST);
            end else begin
              ys_d = prm_q[23:8];
              ye_d = commit_end(prm_q[23:8], {prm_q[7:0], i_byte}, Y_LAST);
            end
          end
        end
        ST_MADCTL_P: begin mad_d = i_byte; state_d = ST_IDLE; end
        ST_RAMWR_HI: begin hi_d = i_byte; state_d = ST_RAMWR_LO; end
        ST_RAMWR_LO: begin
          wr_hit  = in_range;
          state_d = ST_RAMWR_HI;
          if (x_q == xe_q) begin
            x_d = xs_q;
            y_d = (y_q == ye_q) ? ys_q : y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_wr_en     = wr_hit;
  assign o_wr_data   = wr_hit ? {hi_q, i_byte} : 16'h0000;
  assign o_disp_on   = disp_q;
  assign o_madctl    = mad_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_st7735_cmd_ctrl.sv
// Bench for st7735_cmd_ctrl: directed scenarios plus random command streams checked
// against a byte-level model of the command set.
module tb_st7735_cmd_ctrl;
  import st7735_cmd_ctrl_pkg::*;

  localparam int H_RES  = 160;
  localparam int V_RES  = 128;
  localparam int ADDR_W = 15;
  localparam int QW     = ADDR_W + 16;

  logic              i_spi_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [7:0]        i_byte = 8'h00;
  logic              i_byte_valid = 1'b0;
  logic              i_dc = 1'b0;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [15:0]       o_wr_data;
  logic              o_disp_on;
  logic [7:0]        o_madctl;
  logic [2:0]        o_dbg_state;

  st7735_cmd_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .i_spi_clk    (i_spi_clk),
    .i_rst_n      (i_rst_n),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .i_dc         (i_dc),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_disp_on    (o_disp_on),
    .o_madctl     (o_madctl),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_spi_clk = ~i_spi_clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_CASET = 1, M_RASET = 2, M_MAD = 3, M_HI = 4, M_LO = 5, M_SKIP = 6;
  int m_mode, m_xs, m_xe, m_ys, m_ye, m_x, m_y, m_hi, m_disp, m_mad;
  int m_prm[$];

  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] got_q[$];

  task automatic model_reset();
    m_mode = M_IDLE; m_prm.delete();
    m_xs = 0; m_xe = H_RES - 1; m_ys = 0; m_ye = V_RES - 1;
    m_x = 0; m_y = 0; m_hi = 0; m_disp = 0; m_mad = 0;
  endtask

  task automatic model_pixel(input int lo);
    int tx, ty, px, py;
    tx = m_x; ty = m_y;
`ifdef SPI2HDMI_MADCTL_EN
    if (m_mad[5]) begin tx = m_y; ty = m_x; end
    px = m_mad[6] ? (H_RES - 1 - tx) : tx;
    py = m_mad[7] ? (V_RES - 1 - ty) : ty;
`else
    px = tx; py = ty;
`endif
    if (px >= 0 && px < H_RES && py >= 0 && py < V_RES)
      exp_q.push_back({ADDR_W'(py * H_RES + px), 8'(m_hi), 8'(lo)});
    if (m_x == m_xe) begin
      m_x = m_xs;
      if (m_y == m_ye) m_y = m_ys; else m_y = m_y + 1;
    end else begin
      m_x = m_x + 1;
    end
  endtask

  task automatic model_byte(input logic dc, input logic [7:0] b);
    int s, e, lim;
    if (!dc) begin
      case (b)
        8'h2A: begin m_mode = M_CASET; m_prm.delete(); end
        8'h2B: begin m_mode = M_RASET; m_prm.delete(); end
        8'h2C: begin m_mode = M_HI; m_x = m_xs; m_y = m_ys; end
        8'h36: m_mode = M_MAD;
        8'h29: begin m_disp = 1; m_mode = M_IDLE; end
        8'h28: begin m_disp = 0; m_mode = M_IDLE; end
        8'h01: model_reset();
        default: m_mode = M_SKIP;
      endcase
    end else begin
      case (m_mode)
        M_CASET, M_RASET: begin
          m_prm.push_back(int'(b));
          if (m_prm.size() == 4) begin
            s = m_prm[0] * 256 + m_prm[1];
            e = m_prm[2] * 256 + m_prm[3];
            lim = (m_mode == M_CASET) ? H_RES - 1 : V_RES - 1;
            if (e > lim) e = lim;
            if (s > e) e = s;
            if (m_mode == M_CASET) begin m_xs = s; m_xe = e; end
            else begin m_ys = s; m_ye = e; end
            m_mode = M_IDLE;
          end
        end
        M_MAD: begin m_mad = int'(b); m_mode = M_IDLE; end
        M_HI:  begin m_hi = int'(b); m_mode = M_LO; end
        M_LO:  begin model_pixel(int'(b)); m_mode = M_HI; end
        default: ;
      endcase
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge i_spi_clk) begin
    logic [QW-1:0] exp;
    if (i_rst_n && o_wr_en) begin
      got_q.push_back({o_wr_addr, o_wr_data});
      if (exp_q.size() == 0) begin
        check_eq("unexpected_wr", o_wr_en, 1'b0);
      end else begin
        exp = exp_q.pop_front();
        check_eq("wr_addr", o_wr_addr, exp[QW-1:16]);
        check_eq("wr_data", o_wr_data, exp[15:0]);
      end
    end
  end

  // ---------------- drivers (entered and left at posedge + 1) ----------------
  task automatic send_byte(input logic dc, input logic [7:0] b);
    i_dc = dc; i_byte = b; i_byte_valid = 1'b1;
    model_byte(dc, b);
    @(posedge i_spi_clk); #1;
    i_byte_valid = 1'b0;
    i_dc = 1'($urandom_range(0, 1));
    i_byte = 8'($urandom_range(0, 255));
    check_eq("missed_wr", exp_q.size(), 0);
    check_eq("disp_on", o_disp_on, m_disp);
    check_eq("madctl", o_madctl, m_mad);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_spi_clk); #1; end
  endtask

  task automatic send_window(input logic [7:0] op, input int s, input int e);
    send_byte(1'b0, op);
    send_byte(1'b1, 8'(s >> 8)); send_byte(1'b1, 8'(s));
    send_byte(1'b1, 8'(e >> 8)); send_byte(1'b1, 8'(e));
  endtask

  task automatic send_pixel(input logic [15:0] px);
    send_byte(1'b1, px[15:8]);
    send_byte(1'b1, px[7:0]);
  endtask

  // ---------------- stimulus ----------------
  int t2_exp[5] = '{810, 811, 970, 971, 810};
  logic [7:0] unk_ops[5] = '{8'hB1, 8'h00, 8'h3A, 8'hC0, 8'h11};
  int k, n, s, e;

  initial begin
    model_reset();
    repeat (3) @(posedge i_spi_clk);
    #1;
    check_eq("rst_wr_en", o_wr_en, 1'b0);
    check_eq("rst_wr_addr", o_wr_addr, 0);
    check_eq("rst_wr_data", o_wr_data, 0);
    check_eq("rst_disp_on", o_disp_on, 1'b0);
    check_eq("rst_madctl", o_madctl, 8'h00);
    check_eq("rst_state", o_dbg_state, ST_IDLE);
    i_rst_n = 1'b1;
    idle(2);

    // first pixel at origin, second follows at address 1
    got_q.delete();
    send_byte(1'b0, CMD_RAMWR);
    send_pixel(16'hF800);
    send_pixel(16'h1234);
    check_eq("t1_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("t1_addr0", got_q[0][QW-1:16], 0);
      check_eq("t1_data0", got_q[0][15:0], 16'hF800);
      check_eq("t1_addr1", got_q[1][QW-1:16], 1);
    end

    // 2x2 window with wrap back to the top-left corner
    got_q.delete();
    send_window(CMD_CASET, 10, 11);
    send_window(CMD_RASET, 5, 6);
    send_byte(1'b0, CMD_RAMWR);
    for (int i = 0; i < 5; i++) send_pixel(16'(i * 16'h1111));
    check_eq("t2_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_q.size()) check_eq($sformatf("t2_addr%0d", i), got_q[i][QW-1:16], t2_exp[i]);

    // window starting beyond the panel writes nothing
    got_q.delete();
    send_window(CMD_CASET, 200, 250);
    send_byte(1'b0, CMD_RAMWR);
    send_pixel(16'hAAAA);
    send_pixel(16'h5555);
    check_eq("t3_count", got_q.size(), 0);
    send_window(CMD_CASET, 0, 159);
    send_window(CMD_RASET, 0, 127);

    // half pixel aborted by DISPON; stray data then ignored
    got_q.delete();
    send_byte(1'b0, CMD_RAMWR);
    send_byte(1'b1, 8'hAB);
    send_byte(1'b0, CMD_DISPON);
    send_byte(1'b1, 8'h55);
    check_eq("t4_count", got_q.size(), 0);
    check_eq("t4_disp_on", o_disp_on, 1'b1);
    send_byte(1'b0, CMD_RAMWR);
    send_pixel(16'h1234);
    check_eq("t4_count2", got_q.size(), 1);
    if (got_q.size() == 1) check_eq("t4_data", got_q[0][15:0], 16'h1234);

    // MADCTL MX|MY
    got_q.delete();
    send_byte(1'b0, CMD_MADCTL);
    send_byte(1'b1, 8'hC0);
    send_byte(1'b0, CMD_RAMWR);
    send_pixel(16'h07E0);
    check_eq("t5_madctl", o_madctl, 8'hC0);
    check_eq("t5_count", got_q.size(), 1);
`ifdef SPI2HDMI_MADCTL_EN
    if (got_q.size() == 1) check_eq("t5_addr", got_q[0][QW-1:16], 20479);
`else
    if (got_q.size() == 1) check_eq("t5_addr", got_q[0][QW-1:16], 0);
`endif

    // unknown opcode swallows data; SWRESET restores everything
    got_q.delete();
    send_byte(1'b0, 8'hB1);
    send_byte(1'b1, 8'h01); send_byte(1'b1, 8'h2C); send_byte(1'b1, 8'h2D);
    send_byte(1'b0, CMD_SWRESET);
    check_eq("t6_count", got_q.size(), 0);
    check_eq("t6_disp_on", o_disp_on, 1'b0);
    check_eq("t6_madctl", o_madctl, 8'h00);
    check_eq("t6_state", o_dbg_state, ST_IDLE);
    send_byte(1'b0, CMD_RAMWR);
    send_pixel(16'hBEEF);
    check_eq("t6_count2", got_q.size(), 1);
    if (got_q.size() == 1) check_eq("t6_addr", got_q[0][QW-1:16], 0);

    // asynchronous reset while a low byte is on the bus
    send_byte(1'b0, CMD_DISPON);
    send_byte(1'b0, CMD_RAMWR);
    send_byte(1'b1, 8'h77);
    i_dc = 1'b1; i_byte = 8'h99; i_byte_valid = 1'b1;
    #1;
    check_eq("t7_pre_wr_en", o_wr_en, 1'b1);
    i_rst_n = 1'b0;
    #1;
    check_eq("t7_wr_en", o_wr_en, 1'b0);
    check_eq("t7_wr_data", o_wr_data, 0);
    check_eq("t7_wr_addr", o_wr_addr, 0);
    check_eq("t7_disp_on", o_disp_on, 1'b0);
    @(posedge i_spi_clk); #1;
    i_byte_valid = 1'b0;
    model_reset();
    i_rst_n = 1'b1;
    send_byte(1'b1, 8'h12);
    send_byte(1'b0, CMD_RAMWR);
    send_pixel(16'hC0DE);

    // random command streams
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 11);
      case (k)
        0, 1: begin
          s = $urandom_range(0, (k == 0 ? H_RES : V_RES) + 20);
          e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : s + $urandom_range(0, 6);
          if ($urandom_range(0, 4) == 0) begin
            send_byte(1'b0, k == 0 ? CMD_CASET : CMD_RASET);
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) send_byte(1'b1, 8'($urandom_range(0, 255)));
          end else begin
            send_window(k == 0 ? CMD_CASET : CMD_RASET, s, e);
          end
        end
        2, 3, 4, 5: begin
          send_byte(1'b0, CMD_RAMWR);
          n = $urandom_range(0, 30);
          for (int j = 0; j < n; j++) send_pixel(16'($urandom_range(0, 65535)));
          if ($urandom_range(0, 3) == 0) send_byte(1'b1, 8'($urandom_range(0, 255)));
        end
        6: begin
          send_byte(1'b0, CMD_MADCTL);
          send_byte(1'b1, 8'($urandom_range(0, 255)));
        end
        7: send_byte(1'b0, ($urandom_range(0, 1) == 1) ? CMD_DISPON : CMD_DISPOFF);
        8: begin
          send_byte(1'b0, unk_ops[$urandom_range(0, 4)]);
          n = $urandom_range(0, 5);
          for (int j = 0; j < n; j++) send_byte(1'b1, 8'($urandom_range(0, 255)));
        end
        9: send_byte(1'b1, 8'($urandom_range(0, 255)));
        10: if ($urandom_range(0, 3) == 0) send_byte(1'b0, CMD_SWRESET);
        default: idle($urandom_range(1, 4));
      endcase
    end

    idle(3);
    check_eq("final_exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
